fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
- Shares one fixed-latency FP32 add/sub core among NUM_REQ requesters.
- Round-robin arbitration; registers operands into the core and tracks requester ID alongside the core latency.
- Buffers results in an in-order response FIFO with credit-based backpressure.
- Sits between the requesting engines and the add/sub datapath (core inputs a, b, operation_select; output result).

Parameters:
- WIDTH, 32, operand/result width
- EXP_BITS, 8, exponent bits (passed through for the package, unused in control)
- MANT_BITS, 23, mantissa bits (passed through for the package, unused in control)
- NUM_REQ, 4, number of requesters (>=2)
- LAT, 3, core latency in cycles from core_valid to core_result (>=1)
- RSP_DEPTH, LAT+2, response FIFO depth and credit limit

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  grant; handshake when valid&ready
- req_a  in  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand b, same packing
- req_op  in  NUM_REQ  operation_select, 0=add 1=sub
- core_valid  out  1  operands presented to core this cycle
- core_a  out  WIDTH  registered operand a
- core_b  out  WIDTH  registered operand b
- core_op  out  1  registered operation_select
- core_result  in  WIDTH  core output, valid exactly LAT cycles after core_valid
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  $clog2(NUM_REQ)  requester index of head
- rsp_result  out  WIDTH  result of head
- busy  out  1  any operation in flight or buffered

Behaviour:
- Reset (rst_n=0 at posedge): rr_ptr=0, credit count=0, ID/valid shift register cleared, FIFO emptied. Outputs: core_valid=0, core_a=core_b=0, core_op=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0. req_ready=0 while rst_n=0.
- Credit count = issue register + LAT pipeline stages + FIFO occupancy. Never exceeds RSP_DEPTH.
- credit_ok = (count < RSP_DEPTH) || (rsp_valid && rsp_ready).
- Arbitration (combinational):
  - If credit_ok, grant the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready is one-hot or zero; req_ready[i] may only be 1 if req_valid[i]=1.
- On grant at cycle t:
  - rr_ptr <= (granted+1) mod NUM_REQ; rr_ptr is unchanged when nothing is granted.
  - At t+1: core_valid=1 and core_a/b/op hold the granted operands.
  - Granted ID enters a LAT-deep shift register with a valid bit.
- At t+1+LAT: core_result and the ID are written to the FIFO tail. The write is guaranteed to succeed by the credit rule.
- Core timing:
  - core_result is sampled only when the shifted valid bit is set; other cycles are ignored.
  - The core is stateless to this block; no flush signal.
- Response:
  - FIFO is show-ahead; rsp_* reflect the head.
  - Pop on rsp_valid&rsp_ready.
  - Order equals grant order.
- Count update: +1 on grant, -1 on pop; simultaneous grant and pop leaves count unchanged.
- Throughput: sustained one grant per cycle when rsp_ready is held 1. Latency grant→rsp_valid = LAT+2 cycles with an empty FIFO.
- Full: count==RSP_DEPTH and no pop → all req_ready=0; requests hold. Requesters must hold operands stable while req_valid&!req_ready.
- FIFO wrap: pointers wrap modulo RSP_DEPTH. Full and empty are distinguished by the occupancy counter.
- busy = (count != 0).
- Reset mid-operation: in-flight and buffered results are discarded. core_result arriving after reset is ignored because the valid shift register is cleared.

Decomposition:
- Package fp_addsub_pkg:
  - ID width function/localparam ID_W = $clog2(NUM_REQ).
  - Op encoding typedef enum logic {OP_ADD=0, OP_SUB=1}.
  - Response struct {id, result}.
- One sub-module: fp_addsub_rsp_fifo (parameterised depth/width, synchronous active-low reset, show-ahead, occupancy output).
- Round-robin arbiter stays inline.

Test Plan:
- Single add: req 0 with a=0x3F800000, b=0x40000000, op=0; bench core model LAT=3. Expect core_valid 1 cycle after grant, rsp_valid 5 cycles after grant, rsp_id=0, rsp_result=0x40400000.
- Single sub: req 2 with a=0x40400000, b=0x3F800000, op=1. Expect rsp_id=2, rsp_result=0x40000000.
- Round-robin: all 4 requesters hold valid, rsp_ready=1. Expect grant sequence 0,1,2,3,0,1 on consecutive cycles and responses in the same ID order, one per cycle.
- Backpressure: rsp_ready=0, all requesting. Expect exactly 5 grants, then req_ready=0000 with count=5. Raise rsp_ready; expect 5 in-order responses and granting to resume in the same cycle as the first pop.
- Simultaneous grant+pop at full: count stays 5; no FIFO overflow or loss over 100 random cycles, checked against a scoreboard.
- Reset mid-op: 3 operations in flight, pull rst_n low for 1 cycle. Expect rsp_valid=0, busy=0, rr_ptr=0 next cycle; stale core_result values never appear on rsp_result.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared widths, op encoding and response record for the FP add/sub arbiter
package fp_addsub_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fmt_w(input int exp_bits, input int mant_bits);
        return 1 + exp_bits + mant_bits;
    endfunction

    localparam int ID_W = id_w(NUM_REQ_DEF);

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [WIDTH_DEF-1:0] result;
    } rsp_t;

endpackage

// File: rtl/fp_addsub_rsp_fifo.sv
// fp_addsub_rsp_fifo: show-ahead response FIFO with occupancy count
module fp_addsub_rsp_fifo #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 34
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_rd;

    assign rd_valid = occ != '0;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign do_rd    = rd_en & rd_valid;

    // pointers wrap at DEPTH; the occupancy count tells full from empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            occ <= occ + OW'(wr_en) - OW'(do_rd);
        end
    end

    // storage is not reset; the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one fixed-latency FP32 add/sub core with credit-limited in-order responses
module fp_addsub_arbiter
    import fp_addsub_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int NUM_REQ   = 4,
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = LAT + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_op,
    output logic                       core_valid,
    output logic [WIDTH-1:0]           core_a,
    output logic [WIDTH-1:0]           core_b,
    output logic                       core_op,
    input  logic [WIDTH-1:0]           core_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_result,
    output logic                       busy
);

    localparam int IW    = id_w(NUM_REQ);
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int DW    = IW + WIDTH;
    localparam int FMT_W = fmt_w(EXP_BITS, MANT_BITS);

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [IW-1:0]    rr_ptr, gnt_id, iss_id;
    logic             gnt_any, credit_ok, pop;
    logic [CW-1:0]    cnt, fifo_occ;
    op_e              iss_op;
    logic [LAT-1:0]   sr_v;
    logic [IW-1:0]    sr_id [LAT];
    logic [DW-1:0]    fifo_rd;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    assign pop       = rsp_valid & rsp_ready;
    assign credit_ok = (cnt < CW'(RSP_DEPTH)) | pop;
    assign req_ready = gnt_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
    assign core_op   = iss_op;
    assign busy      = cnt != '0;

    // round-robin search from rr_ptr with wrap; the nearest valid requester wins
    always_comb begin
        int idx;
        logic [IW-1:0] cand;
        idx     = 0;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx  = int'(rr_ptr) + k;
            idx  = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            cand = IW'(idx);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
        gnt_any = gnt_any & credit_ok & rst_n;
    end

    // pointer moves past the winner; credits count every op from grant until pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (gnt_any) rr_ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            cnt <= cnt + CW'(gnt_any) - CW'(pop);
        end
    end

    // issue register drives the core one cycle after the grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_valid <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            iss_op     <= OP_ADD;
            iss_id     <= '0;
        end else begin
            core_valid <= gnt_any;
            if (gnt_any) begin
                core_a <= a_arr[gnt_id];
                core_b <= b_arr[gnt_id];
                iss_op <= op_e'(req_op[gnt_id]);
                iss_id <= gnt_id;
            end
        end
    end

    // requester ID travels beside the core so it lines up with core_result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_v <= '0;
            for (int j = 0; j < LAT; j++) sr_id[j] <= '0;
        end else begin
            sr_v[0]  <= core_valid;
            sr_id[0] <= iss_id;
            for (int j = 1; j < LAT; j++) begin
                sr_v[j]  <= sr_v[j-1];
                sr_id[j] <= sr_id[j-1];
            end
        end
    end

    fp_addsub_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DW)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (sr_v[LAT-1]),
        .wr_data  ({sr_id[LAT-1], core_result}),
        .rd_en    (pop),
        .rd_valid (rsp_valid),
        .rd_data  (fifo_rd),
        .occ      (fifo_occ)
    );

    assign {rsp_id, rsp_result} = fifo_rd;

    // the FIFO only ever holds slots already reserved by the credit count
    always_comb begin
        assert (FMT_W == WIDTH && (!rst_n || fifo_occ <= cnt));
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: scoreboard bench with a 3-cycle core model behind the arbiter
`timescale 1ns/1ps
module tb_fp_addsub_arbiter;
    import fp_addsub_pkg::*;

    localparam int NR    = 4;
    localparam int W     = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = LAT + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_op = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a, req_b;
    logic            core_valid, core_op, rsp_valid, busy;
    logic            rsp_ready = 1'b1;
    logic [W-1:0]    core_a, core_b, core_result, rsp_result;
    logic [1:0]      rsp_id;

    logic [W-1:0]    a_of [NR];
    logic [W-1:0]    b_of [NR];
    logic [W-1:0]    pr [LAT];
    logic [LAT-1:0]  pv = '0;
    logic [NR-1:0]   hs = '0;
    logic [NR-1:0]   refill = '0;
    rsp_t            sb[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              n_gnt = 0;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_a[g*W +: W] = a_of[g];
        assign req_b[g*W +: W] = b_of[g];
    end

    fp_addsub_arbiter #(
        .WIDTH(W), .EXP_BITS(8), .MANT_BITS(23), .NUM_REQ(NR), .LAT(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b), .core_op(core_op),
        .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fmodel(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op) return 32'h4000_0000;
        return (a ^ {b[15:0], b[31:16]}) + {31'd0, op};
    endfunction

    function automatic int gid(input logic [NR-1:0] r);
        int g;
        g = -1;
        for (int i = 0; i < NR; i++) if (r[i]) g = i;
        return g;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i);
        a_of[2'(i)] = $urandom;
        b_of[2'(i)] = $urandom;
        req_op[2'(i)] = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                if (refill[i]) load(i);
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        step();
        refill = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            step();
        end
        check("drain_idle", busy, 0);
        check("drain_sb_empty", sb.size(), 0);
        step();
    endtask

    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], core_valid};
        pr[0] <= fmodel(core_a, core_b, core_op);
        for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
    end
    assign core_result = pv[LAT-1] ? pr[LAT-1] : 32'hDEAD_BEEF;

    always @(negedge clk) begin : mon
        rsp_t e;
        int g;
        hs = req_valid & req_ready;
        if (!rst_n) begin
            sb.delete();
        end else begin
            check("ready_needs_valid", req_ready & ~req_valid, 0);
            check("ready_onehot", $countones(req_ready) <= 1, 1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_result", rsp_result, e.result);
                end
            end
            if (hs != '0) begin
                g = gid(hs);
                n_gnt++;
                sb.push_back('{id: 2'(g), result: fmodel(a_of[2'(g)], b_of[2'(g)], req_op[2'(g)])});
                check("credit_limit", sb.size() <= DEPTH, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cv_at, rv_at, g0;
        for (int i = 0; i < NR; i++) begin
            a_of[i] = '0;
            b_of[i] = '0;
        end
        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_core_valid", core_valid, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        check("rst_core_op", core_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        step();
        req_valid = '0;
        rst_n = 1'b1;
        step();

        a_of[0] = 32'h3F80_0000;
        b_of[0] = 32'h4000_0000;
        req_op[0] = 1'b0;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("add_grant", req_ready, 4'b0001);
        cv_at = -1;
        rv_at = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            if (core_valid && cv_at < 0) begin
                cv_at = k;
                check("add_core_a", core_a, 32'h3F80_0000);
                check("add_core_b", core_b, 32'h4000_0000);
            end
            if (rsp_valid && rv_at < 0) begin
                rv_at = k;
                check("add_rsp_id", rsp_id, 0);
                check("add_rsp_result", rsp_result, 32'h4040_0000);
            end
        end
        check("add_core_lat", cv_at, 1);
        check("add_rsp_lat", rv_at, 5);
        step();

        a_of[2] = 32'h4040_0000;
        b_of[2] = 32'h3F80_0000;
        req_op[2] = 1'b1;
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("sub_grant", req_ready, 4'b0100);
        rv_at = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            if (core_valid && k == 1) check("sub_core_op", core_op, 1);
            if (rsp_valid && rv_at < 0) begin
                rv_at = k;
                check("sub_rsp_id", rsp_id, 2);
                check("sub_rsp_result", rsp_result, 32'h4000_0000);
            end
        end
        check("sub_rsp_lat", rv_at, 5);
        step();

        apply_reset();
        for (int i = 0; i < NR; i++) load(i);
        refill = '1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rr_grant", gid(req_ready), k % NR);
            if (k >= LAT + 2) check("rr_rsp_stream", rsp_valid, 1);
            step();
        end
        drain();

        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) load(i);
        refill = '1;
        req_valid = '1;
        g0 = n_gnt;
        repeat (10) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        check("bp_grants", n_gnt - g0, DEPTH);
        check("bp_blocked", req_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_rsp_head", rsp_valid, 1);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_resume", |req_ready, 1);
        for (int k = 0; k < 100; k++) begin
            step();
            rsp_ready = 1'($urandom);
            @(negedge clk);
        end
        drain();

        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) load(i);
        refill = '1;
        req_valid = '1;
        repeat (3) begin
            @(negedge clk);
            step();
        end
        refill = '0;
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_core_valid", core_valid, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            check("midrst_stale", rsp_valid, 0);
        end
        step();
        req_valid = '1;
        @(negedge clk);
        check("midrst_rr_ptr", gid(req_ready), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
